// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed driver for a 4-digit common-anode seven-segment display.
// A one-cycle load strobe captures a 16-bit value into a shadow register. The
// shadow is copied to the visible register only on the tick that ends digit 3,
// so a frame never shows a mix of old and new digits. All outputs are registered.
//
// load/updated handshake: load is a single-cycle strobe with no ready; it is
// always accepted, and a newer load overwrites an older pending one. updated is
// a single-cycle pulse, in the cycle after the frame-boundary edge on which the
// captured value became the displayed value.
module seg7_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        updated
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       digit;
  logic [15:0]      shadow;
  logic [3:0]       shadow_dp;
  logic             pending;
  logic [15:0]      disp;
  logic [3:0]       disp_dp;

  logic             tick;
  logic             commit;
  logic             in_blank;
  logic [3:0]       nib;
  logic             lz_hide;
  logic [3:0]       an_d;
  logic [6:0]       seg_d;
  logic             dp_d;

  // Active-high font, bit 0 = segment a ... bit 6 = segment g.
  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] f;
    case (n)
      4'h0: f = 7'h3F;
      4'h1: f = 7'h06;
      4'h2: f = 7'h5B;
      4'h3: f = 7'h4F;
      4'h4: f = 7'h66;
      4'h5: f = 7'h6D;
      4'h6: f = 7'h7D;
      4'h7: f = 7'h07;
      4'h8: f = 7'h7F;
      4'h9: f = 7'h6F;
      4'hA: f = 7'h77;
      4'hB: f = 7'h7C;
      4'hC: f = 7'h39;
      4'hD: f = 7'h5E;
      4'hE: f = 7'h79;
      default: f = 7'h71;
    endcase
    return f;
  endfunction

  // Slot end and frame-boundary commit conditions.
  always_comb begin
    tick   = (cnt == CNT_MAX);
    commit = tick && (digit == 2'd3) && pending;
  end

  // Slot counter: 0..REFRESH_DIV-1, wrapping on tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Digit index advances once per slot, wrapping 3 -> 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit <= 2'd0;
    end else if (tick) begin
      digit <= digit + 2'd1;
    end
  end

  // Shadow capture; a load in the commit cycle keeps pending set because the
  // commit below still takes the old shadow contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow    <= 16'h0000;
      shadow_dp <= 4'h0;
      pending   <= 1'b0;
    end else begin
      if (load) begin
        shadow    <= value_in;
        shadow_dp <= dp_in;
      end
      if (load) begin
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

  // Visible register, updated only at the digit-3 frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp    <= 16'h0000;
      disp_dp <= 4'h0;
    end else if (commit) begin
      disp    <= shadow;
      disp_dp <= shadow_dp;
    end
  end

  // Next output values from the current slot position and visible data.
  always_comb begin
    in_blank = (cnt < BLANK_END);
    nib      = disp[{digit, 2'b00} +: 4];
    case (digit)
      2'd3:    lz_hide = (disp[15:12] == 4'h0);
      2'd2:    lz_hide = (disp[15:8]  == 8'h00);
      2'd1:    lz_hide = (disp[15:4]  == 12'h000);
      default: lz_hide = 1'b0;
    endcase
    lz_hide = lz_hide && blank_lz;
    an_d  = 4'b1111;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (!in_blank) begin
      an_d  = ~(4'b0001 << digit);
      seg_d = lz_hide ? 7'h7F : ~font(nib);
      dp_d  = ~disp_dp[digit];
    end
  end

  // Registered outputs: one clock behind the slot state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an      <= 4'b1111;
      seg     <= 7'h7F;
      dp      <= 1'b1;
      updated <= 1'b0;
    end else begin
      an      <= an_d;
      seg     <= seg_d;
      dp      <= dp_d;
      updated <= commit;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with REFRESH_DIV=8, BLANK_CYC=2.
// Timeline convention: edges counts rising edges since reset release. The
// outputs after edge t reflect slot position (t-1) mod 8 of digit
// ((t-1)/8) mod 4, so frame k, digit d is blank after edges 32k+8d+1..2 and
// lit after edges 32k+8d+3..8. A commit happens on edge 32(k+1).
module tb_seg7_scan;

  logic        clk;
  logic        rst;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        updated;

  int tests;
  int fails;
  int edges;
  int upd_total;
  int upd_base;

  logic [3:0] an_tab [4];

  seg7_scan #(.REFRESH_DIV(8), .BLANK_CYC(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .value_in (value_in),
    .dp_in    (dp_in),
    .load     (load),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .updated  (updated)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count updated pulses, sampled just after each rising edge.
  initial upd_total = 0;
  always @(posedge clk) begin
    #1;
    if (updated === 1'b1) upd_total++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @edge %0d: got %h expected %h", tag, edges, got, exp);
    end
  endtask

  // Advance to the falling edge after rising edge e.
  task automatic run_to(input int e);
    while (edges < e) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  // Present a load so that it is captured on rising edge e.
  task automatic do_load(input int e, input logic [15:0] v, input logic [3:0] d);
    run_to(e - 1);
    value_in = v;
    dp_in    = d;
    load     = 1'b1;
    run_to(e);
    load     = 1'b0;
  endtask

  // Assert reset mid-cycle, check the immediate effect, release on a falling edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check(tag, {20'h0, an, seg, dp, updated}, {20'h0, 4'b1111, 7'h7F, 1'b1, 1'b0});
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b0;
    edges    = 0;
    upd_base = upd_total;
  endtask

  task automatic check_slot(input string tag, input int k, input int d,
                            input logic [6:0] s, input logic dpb);
    int base;
    base = 32 * k + 8 * d;
    for (int o = 1; o <= 2; o++) begin
      run_to(base + o);
      check($sformatf("%s_f%0d_d%0d_blank", tag, k, d), {20'h0, an, seg, dp},
            {20'h0, 4'b1111, 7'h7F, 1'b1});
    end
    for (int o = 3; o <= 8; o++) begin
      run_to(base + o);
      check($sformatf("%s_f%0d_d%0d_lit", tag, k, d), {20'h0, an, seg, dp},
            {20'h0, an_tab[d], s, dpb});
    end
  endtask

  // segs = {d3, d2, d1, d0} active-low patterns; dpb = active-low dp per digit.
  task automatic check_frame(input string tag, input int k,
                             input logic [27:0] segs, input logic [3:0] dpb);
    for (int d = 0; d < 4; d++) begin
      check_slot(tag, k, d, segs[d*7 +: 7], dpb[d]);
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    edges     = 0;
    upd_base  = 0;
    an_tab[0] = 4'b1110;
    an_tab[1] = 4'b1101;
    an_tab[2] = 4'b1011;
    an_tab[3] = 4'b0111;
    rst       = 1'b1;
    value_in  = 16'h0;
    dp_in     = 4'h0;
    load      = 1'b0;
    blank_lz  = 1'b0;
    #1;
    check("reset_vals", {20'h0, an, seg, dp, updated}, {20'h0, 4'b1111, 7'h7F, 1'b1, 1'b0});
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b0;
    upd_base = upd_total;

    // 1: async reset during a lit slot, then a zero frame from a clean start.
    run_to(5);
    check("pre_rst_lit", {20'h0, an, seg, dp}, {20'h0, 4'b1110, 7'h40, 1'b1});
    async_reset("async_rst");
    check_frame("zero", 0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);

    // 2: single load 1A2F with dp on digit 2.
    async_reset("rst2");
    do_load(10, 16'h1A2F, 4'b0100);
    run_to(31);
    check("upd_before_commit", {31'h0, updated}, 32'h0);
    check("upd_cnt_before", upd_total - upd_base, 0);
    run_to(32);
    check("upd_at_commit", {31'h0, updated}, 32'h1);
    check_frame("1a2f", 1, {7'h79, 7'h08, 7'h24, 7'h0E}, 4'b1011);
    check("upd_cnt_single", upd_total - upd_base, 1);

    // 3: two loads in one frame; old value held until the boundary.
    do_load(66, 16'h1111, 4'h0);
    do_load(70, 16'h2222, 4'h0);
    check_slot("hold", 2, 2, 7'h08, 1'b0);
    check_frame("2222", 3, {7'h24, 7'h24, 7'h24, 7'h24}, 4'b1111);
    check("upd_cnt_b2b", upd_total - upd_base, 2);

    // 4: load exactly on the commit edge.
    do_load(130, 16'h3333, 4'h0);
    do_load(160, 16'h4444, 4'b1001);
    check_frame("3333", 5, {7'h30, 7'h30, 7'h30, 7'h30}, 4'b1111);
    check_frame("4444", 6, {7'h19, 7'h19, 7'h19, 7'h19}, 4'b0110);
    check("upd_cnt_commit_load", upd_total - upd_base, 4);

    // 5: leading-zero blanking.
    run_to(224);
    blank_lz = 1'b1;
    do_load(226, 16'h0050, 4'h0);
    check_frame("lz0050", 8, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111);
    do_load(290, 16'h0000, 4'h0);
    check_frame("lz0000", 10, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111);
    check("upd_cnt_lz", upd_total - upd_base, 6);
    blank_lz = 1'b0;

    // 6: reset while a load is pending; the pending value is discarded.
    do_load(356, 16'hBEEF, 4'hF);
    check_slot("lz_off", 11, 1, 7'h40, 1'b1);
    run_to(372);
    check("pre_rst6_lit", {20'h0, an, seg, dp}, {20'h0, 4'b1011, 7'h40, 1'b1});
    async_reset("rst_pending");
    check_frame("post_rst0", 0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);
    check_frame("post_rst1", 1, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);
    check("upd_cnt_after_rst", upd_total - upd_base, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Multiplexed seven-segment display driver for the board's 4-digit common-anode display. It is the output-side counterpart of the pushbutton debouncer: the debouncer turns a noisy board input into a clean one-cycle pulse, and this block turns processor data into a stable, tear-free board output. A one-cycle `load` strobe captures a 16-bit value from the pipeline (register or PC) and shows it as hex digits. The new value is committed only at a frame boundary.

## Interface
- `REFRESH_DIV`, 100000: clk cycles per digit slot (1 kHz digit rate at 100 MHz); legal range is greater than `BLANK_CYC`+1.
- `BLANK_CYC`, 16: cycles at the start of each slot with all anodes off (anti-ghosting); legal range is at least 0.
- `clk` in, 1: system clock.
- `rst` in, 1: asynchronous, active-high reset.
- `value_in` in, 16: value to display; nibble k goes to digit k, and digit 0 is rightmost.
- `dp_in` in, 4: decimal-point enables per digit, captured together with `value_in`.
- `load` in, 1: one-cycle capture strobe, typically driven by the debouncer output.
- `blank_lz` in, 1: level input that enables leading-zero blanking; sampled every cycle.
- `an` out, 4: anode enables, active-low, one-hot-low or all-high.
- `seg` out, 7: segments, active-low; `seg[0]`=a … `seg[6]`=g.
- `dp` out, 1: decimal point, active-low.
- `updated` out, 1: one-cycle pulse when a captured value becomes visible.

## Operation
- **Shadow capture.** When `load`=1, `shadow` ← `value_in` and `shadow_dp` ← `dp_in`, and `pending` ← 1. A second load while pending overwrites the shadow (last wins).
- **Slot counter.** `cnt` counts 0..`REFRESH_DIV`-1 and wraps. A wrap is a `tick`.
- **Digit index.** On each `tick`, `digit` ← `digit`+1, wrapping 3→0.
- **Frame commit.** This happens on a `tick` where `digit`==3 and `pending`==1:
  - `disp` ← `shadow` and `disp_dp` ← `shadow_dp`;
  - `pending` ← 0;
  - `updated` pulses for 1 cycle (the cycle after the tick edge).
- **Load on the commit cycle.** If `load` is asserted in the same cycle as a commit, the commit takes the old shadow, the shadow takes the new value, and `pending` stays 1.
- **Blanking window.** While `cnt` < `BLANK_CYC`, `an`=4'b1111, `seg`=7'h7F and `dp`=1.
- **Display window.** Otherwise:
  - `an` has bit `digit` low;
  - `seg` = ~font(`disp` nibble `digit`);
  - `dp` = ~`disp_dp[digit]`.
- **Font.** Active-high, g..a, by nibble value: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- **Leading-zero blanking.** When `blank_lz`=1, digit k>0 is blanked (`seg`=7'h7F) if nibbles k..3 of `disp` are all zero. Digit 0 is never blanked. The anode is still driven. The `dp` bit is unaffected.

## Timing
- `an`, `seg`, `dp` and `updated` are all registered, with exactly one clk of latency from `cnt`/`digit` state.
- **Reset values:**
  - `cnt`=0, `digit`=0, `disp`=0, `disp_dp`=0, `shadow`=0, `shadow_dp`=0, `pending`=0;
  - `an`=4'b1111, `seg`=7'h7F, `dp`=1, `updated`=0.
- **Load-to-visible latency.** At most 4·`REFRESH_DIV`+1 cycles, and at least 1 cycle plus the time remaining to the next digit-3 tick.
- **Frame period.** 4·`REFRESH_DIV` cycles. Each digit is lit for `REFRESH_DIV`-`BLANK_CYC` cycles per frame.
- **Reset mid-operation.** An asserted `rst` clears everything immediately, including any pending value. The first slot after release is digit 0 with `cnt`=0, so it starts blanked.
- `blank_lz` changes take effect on the next registered output with no frame sync.

## Test plan
Use `REFRESH_DIV`=8 and `BLANK_CYC`=2 for all scenarios.
1. **Reset.** Assert `rst` asynchronously mid-cycle → outputs go to `an`=1111, `seg`=7F, `dp`=1, `updated`=0 without waiting for a clk edge. After release: 2 blank cycles, then `an`=1110 and `seg`=~3F=7'h40.
2. **Single load.** Load 16'h1A2F with `dp_in`=4'b0100 → `updated` pulses once, after the digit-3→0 tick. The next frame shows:
   - digit0 `seg`=~71;
   - digit1 `seg`=~5B;
   - digit2 `seg`=~77 with `dp`=0;
   - digit3 `seg`=~06.
   
   `an` follows 1110, 1101, 1011, 0111, and each slot has 6 lit cycles after 2 blank cycles.
3. **Back-to-back loads.** Load 16'h1111, then load 16'h2222 within the same frame → only one `updated` pulse, and all digits show `seg`=~5B.
4. **Load on the commit cycle.** Load 16'h3333 pending, then load 16'h4444 exactly on the digit-3 tick → 3333 is displayed for one frame with an `updated` pulse. 4444 follows at the next frame with a second `updated` pulse.
5. **Leading-zero blanking.** Set `blank_lz`=1, display 16'h0050 → digits 3 and 2 have `seg`=7F with their anodes active, digit1 `seg`=~6D, and digit0 `seg`=~3F. Display 16'h0000 → only digit 0 lit, showing ~3F.
6. **Reset with pending load.** Load 16'hBEEF, then assert `rst` before commit → after release the display shows 0000 and no `updated` pulse ever occurs for BEEF.
